sipo_load_ctrl: RTL and testbench

Sequencer for the 8-bit serial-in/parallel-out shift register (ports clk, rst, SI, latch, PO). Accepts a parallel word over a valid/ready handshake. Drives it bit-serially onto the register's SI input, then pulses latch once so PO updates atomically. Sits between a byte-producing master (CPU/FSM) and one SIPO instance; one frame in flight at a time.

---
 rtl/sipo_load_ctrl_if.sv | 30 +++
 rtl/sipo_load_ctrl.sv | 83 ++++++++
 tb/tb_sipo_load_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/sipo_load_ctrl_if.sv
`timescale 1ns/1ps
// sipo_load_ctrl_if: word handshake plus SIPO drive lines for sipo_load_ctrl.
// frame_cnt exists only when SIPO_LOAD_CTRL_FRAME_CNT_EN is defined.
interface sipo_load_ctrl_if #(parameter int WIDTH = 8);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             si;
   logic             shift_en;
   logic             latch;
   logic             busy;
   logic             done;
`ifdef SIPO_LOAD_CTRL_FRAME_CNT_EN
   logic [15:0]      frame_cnt;
`endif
   modport master (
      output in_data, in_valid,
      input  in_ready, si, shift_en, latch, busy, done
`ifdef SIPO_LOAD_CTRL_FRAME_CNT_EN
      , input frame_cnt
`endif
   );
   modport slave (
      input  in_data, in_valid,
      output in_ready, si, shift_en, latch, busy, done
`ifdef SIPO_LOAD_CTRL_FRAME_CNT_EN
      , output frame_cnt
`endif
   );
endinterface

// File: rtl/sipo_load_ctrl.sv
`timescale 1ns/1ps
// sipo_load_ctrl: accepts a word over valid/ready, shifts it onto a SIPO's SI, then pulses latch.
// Optional SIPO_LOAD_CTRL_FRAME_CNT_EN adds a 16-bit completed-frame counter.
module sipo_load_ctrl #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter int GAP       = 0
) (
   input logic             clk,
   input logic             rst,
   sipo_load_ctrl_if.slave bus
);
   localparam int CW = $clog2(WIDTH) + 1;
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH, S_GAP} state_t;
   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [3:0]       gap_q, gap_d;
   logic [WIDTH-1:0] buf_q, buf_d;
   logic             ready_q, si_q, shift_en_q, latch_q, busy_q;
   logic             next_bit;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;
      buf_d   = buf_q;
      case (state_q)
         S_IDLE: if (bus.in_valid) begin
            state_d = S_SHIFT;
            cnt_d   = '0;
            buf_d   = bus.in_data;
         end
         S_SHIFT: begin
            cnt_d   = cnt_q + 1'b1;
            buf_d   = MSB_FIRST ? (buf_q << 1) : (buf_q >> 1);
            state_d = (cnt_q == CW'(WIDTH - 1)) ? S_LATCH : S_SHIFT;
         end
         S_LATCH: begin
            gap_d   = '0;
            state_d = (GAP > 0) ? S_GAP : S_IDLE;
         end
         default: begin
            gap_d   = gap_q + 1'b1;
            state_d = (gap_q == 4'(GAP - 1)) ? S_IDLE : S_GAP;
         end
      endcase
   end
   // The outgoing bit always sits at one end of the buffer, which shifts after every SHIFT cycle.
   assign next_bit = MSB_FIRST ? buf_d[WIDTH-1] : buf_d[0];
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         gap_q      <= '0;
         buf_q      <= '0;
         ready_q    <= 1'b1;
         si_q       <= 1'b0;
         shift_en_q <= 1'b0;
         latch_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         gap_q      <= gap_d;
         buf_q      <= buf_d;
         ready_q    <= state_d == S_IDLE;
         si_q       <= state_d == S_SHIFT && next_bit;
         shift_en_q <= state_d == S_SHIFT;
         latch_q    <= state_d == S_LATCH;
         busy_q     <= state_d != S_IDLE;
      end
   end
   assign bus.in_ready = ready_q & ~rst;
   assign bus.si       = si_q & ~rst;
   assign bus.shift_en = shift_en_q & ~rst;
   assign bus.latch    = latch_q & ~rst;
   assign bus.done     = latch_q & ~rst;
   assign bus.busy     = busy_q & ~rst;
`ifdef SIPO_LOAD_CTRL_FRAME_CNT_EN
   logic [15:0] frame_cnt_q;
   always_ff @(posedge clk) frame_cnt_q <= rst ? '0 : frame_cnt_q + 16'(state_q == S_LATCH);
   assign bus.frame_cnt = frame_cnt_q;
`endif
endmodule

// File: tb/tb_sipo_load_ctrl.sv
`timescale 1ns/1ps
// tb_sipo_load_ctrl: two builds (MSB-first/no gap, LSB-first/gap 2) checked against a frame-level model.
module tb_sipo_load_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   sipo_load_ctrl_if #(.WIDTH(8)) ia ();
   sipo_load_ctrl_if #(.WIDTH(8)) ib ();
   sipo_load_ctrl #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(0)) u_a (.clk(clk), .rst(rst), .bus(ia.slave));
   sipo_load_ctrl #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(2)) u_b (.clk(clk), .rst(rst), .bus(ib.slave));
   logic [7:0] din[2];
   logic       vld[2];
   // obs bits: {in_ready, busy, shift_en, si, latch, done}
   logic [5:0] obs[2];
   assign ia.in_data  = din[0];
   assign ia.in_valid = vld[0];
   assign ib.in_data  = din[1];
   assign ib.in_valid = vld[1];
   assign obs[0] = {ia.in_ready, ia.busy, ia.shift_en, ia.si, ia.latch, ia.done};
   assign obs[1] = {ib.in_ready, ib.busy, ib.shift_en, ib.si, ib.latch, ib.done};
   logic [7:0] sr[2];
   logic [7:0] po[2] = '{8'h00, 8'h00};
   int n_acc[2] = '{0, 0};
   int n_latch[2] = '{0, 0};
   int t_last[2] = '{0, 0};
   int t_prev[2] = '{0, 0};
   int frames[2] = '{0, 0};
   // Behavioural SIPO plus accept/latch bookkeeping
   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int d = 0; d < 2; d++) begin
         if (obs[d][3]) sr[d] <= {sr[d][6:0], obs[d][2]};
         if (obs[d][1]) begin
            po[d] <= sr[d];
            n_latch[d] <= n_latch[d] + 1;
         end
         if (vld[d] && obs[d][5]) begin
            n_acc[d] <= n_acc[d] + 1;
            t_prev[d] <= t_last[d];
            t_last[d] <= cyc;
         end
      end
   end
   function automatic logic bit_k(input int d, input logic [7:0] w, input int k);
      return (d == 0) ? w[7-k] : w[k];
   endfunction
   // The SIPO shifts toward its MSB, so the first bit sent lands in PO[7].
   function automatic logic [7:0] sipo_po(input int d, input logic [7:0] w);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = w[7-i];
      return (d == 0) ? w : r;
   endfunction
   task automatic start(input int d, input logic [7:0] w, input bit hold);
      din[d] = w;
      vld[d] = 1'b1;
      @(negedge clk);
      if (!hold) vld[d] = 1'b0;
   endtask
   // Entered at the negedge of the first shift cycle; returns at the negedge where in_ready is back.
   task automatic watch_frame(input int d, input logic [7:0] w, input bit noise);
      logic [5:0] ex;
      int g;
      g = (d == 0) ? 0 : 2;
      for (int k = 0; k < 8; k++) begin
         if (noise && k == 1) begin
            din[d] = 8'hFF;
            vld[d] = 1'b1;
         end
         if (noise && k == 4) vld[d] = 1'b0;
         ex = {3'b011, bit_k(d, w, k), 2'b00};
         n_chk++;
         if (obs[d] !== ex) begin
            n_fail++;
            $display("FAIL shift%0d dut%0d word %h: got %b expected %b", k, d, w, obs[d], ex);
         end
         @(negedge clk);
      end
      n_chk++;
      if (obs[d] !== 6'b010011) begin
         n_fail++;
         $display("FAIL latch dut%0d word %h: got %b expected 010011", d, w, obs[d]);
      end
      frames[d]++;
      @(negedge clk);
      for (int k = 0; k < g; k++) begin
         n_chk++;
         if (obs[d] !== 6'b010000) begin
            n_fail++;
            $display("FAIL gap%0d dut%0d: got %b expected 010000", k, d, obs[d]);
         end
         @(negedge clk);
      end
      n_chk++;
      if (obs[d] !== 6'b100000) begin
         n_fail++;
         $display("FAIL idle dut%0d: got %b expected 100000", d, obs[d]);
      end
      n_chk++;
      if (po[d] !== sipo_po(d, w)) begin
         n_fail++;
         $display("FAIL po dut%0d word %h: got %h expected %h", d, w, po[d], sipo_po(d, w));
      end
   endtask
   task automatic test_reset;
      din[0] = 8'hAA;
      din[1] = 8'h55;
      vld[0] = 1'b1;
      vld[1] = 1'b1;
      repeat (2) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (obs[d] !== 6'b000000) begin
               n_fail++;
               $display("FAIL reset_outs dut%0d: got %b expected 000000", d, obs[d]);
            end
         end
      end
      @(negedge clk);
      rst = 1'b0;
      vld[0] = 1'b0;
      vld[1] = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         n_chk++;
         if (obs[d] !== 6'b100000 || n_acc[d] != 0) begin
            n_fail++;
            $display("FAIL post_reset dut%0d: got %b acc %0d expected 100000 acc 0", d, obs[d], n_acc[d]);
         end
      end
      @(negedge clk);
   endtask
   task automatic test_msb_first;
      start(0, 8'hA5, 1'b0);
      watch_frame(0, 8'hA5, 1'b0);
   endtask
   task automatic test_lsb_first;
      start(1, 8'h01, 1'b0);
      watch_frame(1, 8'h01, 1'b0);
   endtask
   task automatic test_back_to_back;
      int l0;
      l0 = n_latch[1];
      start(1, 8'h3C, 1'b1);
      din[1] = 8'hC3;
      watch_frame(1, 8'h3C, 1'b0);
      @(negedge clk);
      vld[1] = 1'b0;
      watch_frame(1, 8'hC3, 1'b0);
      n_chk++;
      if (t_last[1] - t_prev[1] != 12 || n_latch[1] - l0 != 2) begin
         n_fail++;
         $display("FAIL back_to_back: spacing %0d latches %0d expected 12 and 2", t_last[1] - t_prev[1], n_latch[1] - l0);
      end
   endtask
   task automatic test_in_data_change;
      int a0;
      a0 = n_acc[0];
      start(0, 8'h0F, 1'b0);
      watch_frame(0, 8'h0F, 1'b1);
      repeat (3) @(negedge clk);
      n_chk++;
      if (n_acc[0] != a0 + 1 || obs[0] !== 6'b100000) begin
         n_fail++;
         $display("FAIL ignored_valid: accepts %0d obs %b expected %0d 100000", n_acc[0] - a0, obs[0], 1);
      end
   endtask
   task automatic test_abort;
      int l0;
      l0 = n_latch[0];
      start(0, 8'h81, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_chk++;
      if (obs[0] !== 6'b000000) begin
         n_fail++;
         $display("FAIL abort_rst: got %b expected 000000", obs[0]);
      end
      rst = 1'b0;
      frames[0] = 0;
      frames[1] = 0;
      repeat (12) @(negedge clk);
      n_chk++;
      if (n_latch[0] != l0 || po[0] !== sipo_po(0, 8'h0F) || obs[0] !== 6'b100000) begin
         n_fail++;
         $display("FAIL abort: latches %0d po %h obs %b expected 0 %h 100000", n_latch[0] - l0, po[0], obs[0], sipo_po(0, 8'h0F));
      end
`ifdef SIPO_LOAD_CTRL_FRAME_CNT_EN
      n_chk++;
      if (ia.frame_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL frame_cnt_reset: got %0d expected 0", ia.frame_cnt);
      end
`endif
   endtask
   task automatic test_random;
      logic [7:0] w;
      for (int d = 0; d < 2; d++) begin
         for (int n = 0; n < 20; n++) begin
            repeat ($urandom_range(3, 0)) @(negedge clk);
            w = 8'($urandom);
            start(d, w, 1'b0);
            watch_frame(d, w, 1'b0);
         end
      end
`ifdef SIPO_LOAD_CTRL_FRAME_CNT_EN
      n_chk++;
      if (ia.frame_cnt !== 16'(frames[0]) || ib.frame_cnt !== 16'(frames[1])) begin
         n_fail++;
         $display("FAIL frame_cnt: got %0d/%0d expected %0d/%0d", ia.frame_cnt, ib.frame_cnt, frames[0], frames[1]);
      end
`endif
   endtask
   initial begin
      test_reset;
      test_msb_first;
      test_lsb_first;
      test_back_to_back;
      test_in_data_change;
      test_abort;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
